load_store_unit: RTL and testbench

//  Data-memory stage downstream of the ALU: takes aluresult as the effective address plus rs2 store data.

---
 rtl/riscv_pkg.sv | 12 +
 rtl/lsu_align.sv | 29 ++
 rtl/load_store_unit.sv | 89 ++++++++
 tb/tb_load_store_unit.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg: RV32I load/store funct3 encodings and LSU state type
package riscv_pkg;
  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} lsu_state_t;
endpackage

// File: rtl/lsu_align.sv
// lsu_align: byte-lane enables, store replication, legality checks and load extension
module lsu_align
  import riscv_pkg::*;
(
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  input  logic [31:0] word,
  output logic [3:0]  be,
  output logic [31:0] lane,
  output logic        misaligned,
  output logic        illegal,
  output logic [31:0] ext
);
  logic [31:0] x;
  always_comb begin
    x = word >> {off, 3'b000};
    illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111) || (we && funct3[2]);
    misaligned = (funct3[1:0] == 2'b01 && off[0]) || (funct3[1:0] == 2'b10 && off != 2'b00);
    be = funct3[1:0] == 2'b00 ? 4'b0001 << off : funct3[1:0] == 2'b01 ? 4'b0011 << off : 4'b1111;
    lane = funct3[1:0] == 2'b00 ? {4{wdata[7:0]}} : funct3[1:0] == 2'b01 ? {2{wdata[15:0]}} : wdata;
    ext = funct3 == LB  ? {{24{x[7]}}, x[7:0]} :
          funct3 == LH  ? {{16{x[15]}}, x[15:0]} :
          funct3 == LW  ? x :
          funct3 == LBU ? {24'd0, x[7:0]} :
          funct3 == LHU ? {16'd0, x[15:0]} : 32'd0;
  end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: single-access data memory stage with ready handshake and optional timeout
module load_store_unit
  import riscv_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);
  lsu_state_t state, state_n;
  logic we_q;
  logic [2:0] f3_q, f3;
  logic [1:0] off_q, off;
  logic [31:0] cnt, lane, ext;
  logic [3:0] be;
  logic mis, ill, bad, tout;
  // Alignment unit sees the live request in IDLE and the latched one afterwards
  assign f3 = state == IDLE ? funct3 : f3_q;
  assign off = state == IDLE ? addr[1:0] : off_q;
  assign bad = mis | ill;
  assign tout = (TIMEOUT != 0) && (cnt == 32'(TIMEOUT - 1)) && !mem_ready;
  lsu_align u_align (
    .we(req_we), .funct3(f3), .off(off), .wdata(wdata), .word(mem_rdata),
    .be(be), .lane(lane), .misaligned(mis), .illegal(ill), .ext(ext)
  );
  always_comb begin
    state_n = state == IDLE   ? (req_valid ? (bad ? RESP : ACCESS) : IDLE) :
              state == ACCESS ? (mem_ready || tout ? RESP : ACCESS) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= state_n;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      busy <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
      rdata <= '0;
      mem_req <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_be <= '0;
      mem_wdata <= '0;
      cnt <= '0;
      we_q <= 1'b0;
      f3_q <= '0;
      off_q <= '0;
    end else begin
      busy <= state_n != IDLE;
      done <= state_n == RESP;
      mem_req <= state_n == ACCESS;
      cnt <= state == ACCESS ? cnt + 32'd1 : '0;
      if (state == IDLE && req_valid) begin
        we_q <= req_we;
        f3_q <= funct3;
        off_q <= addr[1:0];
        mem_we <= req_we & ~bad;
        mem_addr <= {addr[31:2], 2'b00};
        mem_be <= be;
        mem_wdata <= lane;
        err <= bad;
        rdata <= '0;
      end else if (state == ACCESS) begin
        if (mem_ready) rdata <= we_q ? '0 : ext;
        else if (tout) err <= 1'b1;
        if (mem_ready || tout) mem_we <= 1'b0;
      end else if (state == RESP) begin
        err <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed vector table plus timeout/reset sequences for the LSU
module tb_load_store_unit;
  logic clk = 1'b0;
  logic reset, req_valid, req_we, mem_ready, rv0, ready0;
  logic [2:0] funct3;
  logic [31:0] addr, wdata, mem_rdata;
  logic busy, done, err, mem_req, mem_we;
  logic [31:0] rdata, mem_addr, mem_wdata;
  logic [3:0] mem_be;
  logic busy0, done0, err0, mem_req0, mem_we0;
  logic [31:0] rdata0, mem_addr0, mem_wdata0;
  logic [3:0] mem_be0;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  load_store_unit #(.TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_we(req_we), .funct3(funct3),
    .addr(addr), .wdata(wdata), .busy(busy), .done(done), .err(err), .rdata(rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  load_store_unit #(.TIMEOUT(0)) dut0 (
    .clk(clk), .reset(reset), .req_valid(rv0), .req_we(req_we), .funct3(funct3),
    .addr(addr), .wdata(wdata), .busy(busy0), .done(done0), .err(err0), .rdata(rdata0),
    .mem_req(mem_req0), .mem_we(mem_we0), .mem_addr(mem_addr0), .mem_be(mem_be0),
    .mem_wdata(mem_wdata0), .mem_ready(ready0), .mem_rdata(mem_rdata)
  );

  typedef struct {
    string       name;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] word;
    logic        err;
    logic [3:0]  be;
    logic [31:0] mwd;
    logic [31:0] rd;
  } vec_t;

  vec_t vecs[12];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  task automatic xact(input vec_t v);
    req_valid = 1'b1;
    req_we = v.we;
    funct3 = v.f3;
    addr = v.addr;
    wdata = v.wdata;
    step();
    req_valid = 1'b0;
    if (v.err) begin
      chk({v.name, " no mem_req"}, 32'(mem_req), 32'd0);
      chk({v.name, " done"}, 32'(done), 32'd1);
      chk({v.name, " err"}, 32'(err), 32'd1);
      chk({v.name, " rdata"}, rdata, 32'd0);
    end else begin
      chk({v.name, " mem_req"}, 32'(mem_req), 32'd1);
      chk({v.name, " mem_we"}, 32'(mem_we), 32'(v.we));
      chk({v.name, " mem_addr"}, mem_addr, {v.addr[31:2], 2'b00});
      chk({v.name, " mem_be"}, 32'(mem_be), 32'(v.be));
      if (v.we) chk({v.name, " mem_wdata"}, mem_wdata, v.mwd);
      chk({v.name, " early done"}, 32'(done), 32'd0);
      mem_ready = 1'b1;
      mem_rdata = v.word;
      step();
      mem_ready = 1'b0;
      chk({v.name, " done"}, 32'(done), 32'd1);
      chk({v.name, " err"}, 32'(err), 32'd0);
      chk({v.name, " rdata"}, rdata, v.rd);
      chk({v.name, " req drop"}, 32'(mem_req), 32'd0);
    end
    step();
    chk({v.name, " done pulse"}, 32'(done), 32'd0);
    chk({v.name, " idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int n;
    bit seen;
    vecs[0]  = '{"lw", 1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 1'b0, 4'b1111, 32'h0, 32'hDEADBEEF};
    vecs[1]  = '{"lb", 1'b0, 3'b000, 32'h103, 32'h0, 32'h80123456, 1'b0, 4'b1000, 32'h0, 32'hFFFFFF80};
    vecs[2]  = '{"lbu", 1'b0, 3'b100, 32'h103, 32'h0, 32'h80123456, 1'b0, 4'b1000, 32'h0, 32'h00000080};
    vecs[3]  = '{"sh", 1'b1, 3'b001, 32'h202, 32'h1234ABCD, 32'h55555555, 1'b0, 4'b1100, 32'hABCDABCD, 32'h0};
    vecs[4]  = '{"lw mis", 1'b0, 3'b010, 32'h101, 32'h0, 32'h0, 1'b1, 4'b0000, 32'h0, 32'h0};
    vecs[5]  = '{"sb f3=100", 1'b1, 3'b100, 32'h100, 32'h0, 32'h0, 1'b1, 4'b0000, 32'h0, 32'h0};
    vecs[6]  = '{"ld f3=011", 1'b0, 3'b011, 32'h100, 32'h0, 32'h0, 1'b1, 4'b0000, 32'h0, 32'h0};
    vecs[7]  = '{"lh mis", 1'b0, 3'b001, 32'h201, 32'h0, 32'h0, 1'b1, 4'b0000, 32'h0, 32'h0};
    vecs[8]  = '{"lh", 1'b0, 3'b001, 32'h102, 32'h0, 32'h80017FFF, 1'b0, 4'b1100, 32'h0, 32'hFFFF8001};
    vecs[9]  = '{"lhu", 1'b0, 3'b101, 32'h102, 32'h0, 32'h80017FFF, 1'b0, 4'b1100, 32'h0, 32'h00008001};
    vecs[10] = '{"sb", 1'b1, 3'b000, 32'h101, 32'h000000A5, 32'h0, 1'b0, 4'b0010, 32'hA5A5A5A5, 32'h0};
    vecs[11] = '{"sw", 1'b1, 3'b010, 32'h300, 32'h11223344, 32'h0, 1'b0, 4'b1111, 32'h11223344, 32'h0};
    reset = 1'b1;
    req_valid = 1'b0;
    rv0 = 1'b0;
    req_we = 1'b0;
    funct3 = 3'b010;
    addr = '0;
    wdata = '0;
    mem_ready = 1'b0;
    ready0 = 1'b0;
    mem_rdata = '0;
    step();
    step();
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst err", 32'(err), 32'd0);
    chk("rst mem_req", 32'(mem_req), 32'd0);
    chk("rst mem_we", 32'(mem_we), 32'd0);
    chk("rst rdata", rdata, 32'd0);
    chk("rst mem_addr", mem_addr, 32'd0);
    chk("rst mem_be", 32'(mem_be), 32'd0);
    chk("rst mem_wdata", mem_wdata, 32'd0);
    reset = 1'b0;
    step();
    foreach (vecs[i]) xact(vecs[i]);
    // timeout: mem_ready never comes
    req_valid = 1'b1;
    req_we = 1'b0;
    funct3 = 3'b010;
    addr = 32'h400;
    step();
    req_valid = 1'b0;
    n = 0;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (mem_req) n++;
      if (done) begin
        seen = 1'b1;
        chk("timeout err", 32'(err), 32'd1);
        chk("timeout rdata", rdata, 32'd0);
        break;
      end
      step();
    end
    chk("timeout done seen", 32'(seen), 32'd1);
    chk("timeout req cycles", 32'(n), 32'd4);
    step();
    chk("timeout idle", 32'(busy), 32'd0);
    // TIMEOUT=0: waits forever, completes after late ready
    rv0 = 1'b1;
    addr = 32'h104;
    step();
    rv0 = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk("t0 still req", 32'(mem_req0), 32'd1);
    chk("t0 no done", 32'(done0), 32'd0);
    ready0 = 1'b1;
    mem_rdata = 32'hCAFEF00D;
    step();
    ready0 = 1'b0;
    chk("t0 done", 32'(done0), 32'd1);
    chk("t0 err", 32'(err0), 32'd0);
    chk("t0 rdata", rdata0, 32'hCAFEF00D);
    step();
    // reset in ACCESS
    req_valid = 1'b1;
    addr = 32'h500;
    step();
    req_valid = 1'b0;
    step();
    chk("pre-rst req", 32'(mem_req), 32'd1);
    reset = 1'b1;
    step();
    chk("rst mid busy", 32'(busy), 32'd0);
    chk("rst mid req", 32'(mem_req), 32'd0);
    chk("rst mid done", 32'(done), 32'd0);
    reset = 1'b0;
    step();
    chk("post-rst no done", 32'(done), 32'd0);
    chk("post-rst no req", 32'(mem_req), 32'd0);
    xact(vecs[0]);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
